scalu_pipe: RTL

Parametrised successor to the single-cycle scalar ALU. It sits between the execute reservation station (exers) and writeback (wb).
- Adds configurable datapath width and pipeline depth.
- Each stage holds data under back-pressure with per-stage valid bits.
- ROB flush kills all in-flight ops.
- Illegal opcodes are reported to the ROB as errors.
- Shift semantics are corrected: SLL is a left shift, op[3] selects SRA, shift amount is masked.

---
 rtl/scalu_pkg.sv | 31 +++
 rtl/scalu_if.sv | 46 ++++
 rtl/scalu_exec.sv | 58 +++++
 rtl/scalu_pipe.sv | 139 +++++++++++++
 4 files changed

// File: rtl/scalu_pkg.sv
// Shared definitions for the pipelined scalar ALU.
// Provides the func codes, op-field bit positions, exception causes and the
// per-stage status payload carried alongside results through the pipe.
package scalu_pkg;

  localparam int unsigned OP_W        = 5;
  localparam int unsigned ECAUSE_W    = 5;
  localparam int unsigned OP_ALT_BIT  = 3;
  localparam int unsigned OP_RSVD_BIT = 4;

  typedef enum logic [2:0] {
    FN_ADD  = 3'b000,
    FN_SLL  = 3'b001,
    FN_SLT  = 3'b010,
    FN_SLTU = 3'b011,
    FN_XOR  = 3'b100,
    FN_SRL  = 3'b101,
    FN_OR   = 3'b110,
    FN_AND  = 3'b111
  } scalu_func_e;

  localparam logic [ECAUSE_W-1:0] ECAUSE_NONE       = 5'd0;
  localparam logic [ECAUSE_W-1:0] ECAUSE_ILLEGAL_OP = 5'd2;

  // Status computed at stage 1 and carried with the result to the last stage.
  typedef struct packed {
    logic                error;
    logic [ECAUSE_W-1:0] ecause;
  } scalu_status_t;

endpackage

// File: rtl/scalu_if.sv
// Issue / result / control bundle between exers, the scalar ALU, wb and the ROB.
// master: the environment side (exers issues, wb back-pressures, ROB flushes).
// slave:  the ALU side (scalu_pipe).
interface scalu_if
  import scalu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ROBID_W = 8,
  parameter int unsigned RD_W    = 6
);

  // exers -> scalu
  logic                exers_scalu_issue;
  logic [OP_W-1:0]     exers_scalu_op;
  logic [ROBID_W-1:0]  exers_robid;
  logic [RD_W-1:0]     exers_rd;
  logic [XLEN-1:0]     exers_op1;
  logic [XLEN-1:0]     exers_op2;
  // scalu -> exers
  logic                scalu_stall;
  // scalu -> wb
  logic                scalu_valid;
  logic                scalu_error;
  logic [ECAUSE_W-1:0] scalu_ecause;
  logic [ROBID_W-1:0]  scalu_robid;
  logic [RD_W-1:0]     scalu_rd;
  logic [XLEN-1:0]     scalu_result;
  // wb / rob -> scalu
  logic                wb_scalu_stall;
  logic                rob_flush;

  modport master (
    output exers_scalu_issue, exers_scalu_op, exers_robid, exers_rd, exers_op1, exers_op2,
    output wb_scalu_stall, rob_flush,
    input  scalu_stall, scalu_valid, scalu_error, scalu_ecause, scalu_robid, scalu_rd,
    input  scalu_result
  );

  modport slave (
    input  exers_scalu_issue, exers_scalu_op, exers_robid, exers_rd, exers_op1, exers_op2,
    input  wb_scalu_stall, rob_flush,
    output scalu_stall, scalu_valid, scalu_error, scalu_ecause, scalu_robid, scalu_rd,
    output scalu_result
  );

endinterface

// File: rtl/scalu_exec.sv
// Combinational scalar ALU core.
// Ports:
//   op     in  {rsvd, alt, func[2:0]}
//   op1    in  operand 1
//   op2    in  operand 2 (low log2(XLEN) bits form the shift amount)
//   result out ALU result, forced to 0 on an illegal op
//   status out {error, ecause}
module scalu_exec
  import scalu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] result,
  output scalu_status_t   status
);

  localparam int unsigned ShW = $clog2(XLEN);

  scalu_func_e     func;
  logic            alt;
  logic            illegal;
  logic [ShW-1:0]  shamt;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] raw;

  assign func  = scalu_func_e'(op[2:0]);
  assign alt   = op[OP_ALT_BIT];
  assign shamt = op2[ShW-1:0];
  assign lt_s  = $signed(op1) < $signed(op2);
  assign lt_u  = op1 < op2;

  // alt is only meaningful for ADD/SUB and SRL/SRA.
  assign illegal = op[OP_RSVD_BIT] | (alt & (func != FN_ADD) & (func != FN_SRL));

  always_comb begin
    raw = '0;
    unique case (func)
      FN_ADD:  raw = alt ? (op1 - op2) : (op1 + op2);
      FN_SLL:  raw = op1 << shamt;
      FN_SLT:  raw = {{(XLEN-1){1'b0}}, lt_s};
      FN_SLTU: raw = {{(XLEN-1){1'b0}}, lt_u};
      FN_XOR:  raw = op1 ^ op2;
      FN_SRL:  raw = alt ? $unsigned($signed(op1) >>> shamt) : (op1 >> shamt);
      FN_OR:   raw = op1 | op2;
      FN_AND:  raw = op1 & op2;
      default: raw = '0;
    endcase
  end

  assign result        = illegal ? '0 : raw;
  assign status.error  = illegal;
  assign status.ecause = illegal ? ECAUSE_ILLEGAL_OP : ECAUSE_NONE;

endmodule

// File: rtl/scalu_pipe.sv
// Pipelined scalar ALU between exers and wb.
// Stage 1 registers the issued op and operands; the result is computed from
// stage 1 and then travels through stages 2..STAGES with robid/rd. Each stage
// has its own valid bit and holds under wb back-pressure; an empty stage lets
// its predecessor move up, so bubbles are squeezed out.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  scalu_if.slave: issue from exers, result to wb, stall, rob_flush
module scalu_pipe
  import scalu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned STAGES  = 1,
  parameter int unsigned ROBID_W = 8,
  parameter int unsigned RD_W    = 6
) (
  input logic    clk,
  input logic    rst,
  scalu_if.slave bus
);

  localparam int unsigned Last = STAGES - 1;

  // Index k here is stage k+1.
  logic [STAGES-1:0]  v_q;
  logic [STAGES-1:0]  v_d;
  logic [STAGES-1:0]  adv;
  logic               stall;
  logic               accept;

  logic [OP_W-1:0]    op_q;
  logic [XLEN-1:0]    op1_q;
  logic [XLEN-1:0]    op2_q;
  logic [ROBID_W-1:0] robid_q [STAGES];
  logic [RD_W-1:0]    rd_q    [STAGES];

  logic [XLEN-1:0]    ex_result;
  scalu_status_t      ex_status;
  logic [XLEN-1:0]    out_result;
  scalu_status_t      out_status;

  // A stage may take new data if it is empty, its successor is empty, or its
  // successor is itself moving on this cycle.
  always_comb begin
    adv       = '0;
    adv[Last] = ~v_q[Last] | ~bus.wb_scalu_stall;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      adv[k] = ~v_q[k] | ~v_q[k+1] | adv[k+1];
    end
  end

  assign stall           = v_q[0] & ~adv[0];
  assign bus.scalu_stall = stall;
  assign accept          = bus.exers_scalu_issue & ~stall & ~bus.rob_flush;

  always_comb begin
    v_d = v_q;
    if (adv[0]) begin
      v_d[0] = accept;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
      end
    end
    if (bus.rob_flush) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // Payload is only qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= bus.exers_scalu_op;
      op1_q      <= bus.exers_op1;
      op2_q      <= bus.exers_op2;
      robid_q[0] <= bus.exers_robid;
      rd_q[0]    <= bus.exers_rd;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (adv[k] && v_q[k-1]) begin
        robid_q[k] <= robid_q[k-1];
        rd_q[k]    <= rd_q[k-1];
      end
    end
  end

  scalu_exec #(
    .XLEN (XLEN)
  ) u_exec (
    .op     (op_q),
    .op1    (op1_q),
    .op2    (op2_q),
    .result (ex_result),
    .status (ex_status)
  );

  if (STAGES > 1) begin : g_res_pipe
    logic [XLEN-1:0] res_q [1:STAGES-1];
    scalu_status_t   st_q  [1:STAGES-1];

    always_ff @(posedge clk) begin
      if (adv[1] && v_q[0]) begin
        res_q[1] <= ex_result;
        st_q[1]  <= ex_status;
      end
      for (int k = 2; k < int'(STAGES); k++) begin
        if (adv[k] && v_q[k-1]) begin
          res_q[k] <= res_q[k-1];
          st_q[k]  <= st_q[k-1];
        end
      end
    end

    assign out_result = res_q[Last];
    assign out_status = st_q[Last];
  end else begin : g_res_comb
    assign out_result = ex_result;
    assign out_status = ex_status;
  end

  // Outputs are zeroed whenever no result is presented.
  assign bus.scalu_valid  = v_q[Last];
  assign bus.scalu_result = v_q[Last] ? out_result        : '0;
  assign bus.scalu_error  = v_q[Last] ? out_status.error  : 1'b0;
  assign bus.scalu_ecause = v_q[Last] ? out_status.ecause : ECAUSE_NONE;
  assign bus.scalu_robid  = v_q[Last] ? robid_q[Last]     : '0;
  assign bus.scalu_rd     = v_q[Last] ? rd_q[Last]        : '0;

endmodule
